// File: rtl/accum20_unit_pkg.sv
// Shared types and constants for the 20-bit accumulator stage.
package accum20_unit_pkg;

  localparam int DW = 20;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/accum20_unit_cla.sv
// 20-bit carry-lookahead adder/subtractor: 4-bit lookahead groups, group carries chained.
module Bit20CLAAdder
  import accum20_unit_pkg::*;
(
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          SUB,
  output logic [DW-1:0] Sum,
  output logic          Carry,
  output logic          OVF
);

  logic [DW-1:0] bx;
  logic [DW-1:0] g;
  logic [DW-1:0] p;
  logic [DW:0]   c;

  assign bx = B ^ {DW{SUB}};
  assign g  = A & bx;
  assign p  = A ^ bx;

  // SUB is A + ~B + 1, so the inverted operand plus carry-in of 1
  always_comb begin
    c    = '0;
    c[0] = SUB;
    for (int k = 0; k < DW / 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign Sum   = p ^ c[DW-1:0];
  assign Carry = c[DW];
  assign OVF   = c[DW] ^ c[DW-1];

endmodule

// File: rtl/accum20_unit.sv
// Accumulator stage: command handshake in, result handshake out, around the CLA adder.
// state | meaning
// IDLE  | waiting for a command, in_ready=1
// EXEC  | adder evaluating acc_q op opnd_q, registers update on exit
// HOLD  | result presented, held until out_ready
module accum20_unit
  import accum20_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_acc,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  state_e          state_q;
  op_e             op_q;
  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   opnd_q;
  logic            carry_q;
  logic            ovf_q;
  logic            sticky_q;
  logic [CNT_W-1:0] count_q;

  logic [DW-1:0]   add_sum;
  logic            add_carry;
  logic            add_ovf;
  logic            out_fire;
  logic            is_arith;

  Bit20CLAAdder u_cla (
    .A     (acc_q),
    .B     (opnd_q),
    .SUB   (op_q == OP_SUB),
    .Sum   (add_sum),
    .Carry (add_carry),
    .OVF   (add_ovf)
  );

  assign out_valid = (state_q == HOLD);
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign out_fire  = out_valid && out_ready;
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      acc_q    <= '0;
      opnd_q   <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (clr_sticky) sticky_q <= 1'b0;
      if (out_fire && (count_q != {CNT_W{1'b1}})) count_q <= count_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op_e'(in_op);
            opnd_q  <= in_data;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_ADD, OP_SUB: begin
              acc_q   <= add_sum;
              carry_q <= add_carry;
              ovf_q   <= add_ovf;
            end
            OP_LOAD: begin
              acc_q   <= opnd_q;
              carry_q <= 1'b0;
              ovf_q   <= 1'b0;
            end
            default: begin
              acc_q   <= '0;
              carry_q <= 1'b0;
              ovf_q   <= 1'b0;
            end
          endcase
          // placed after the clear so a coincident set wins
          if (is_arith && add_ovf) sticky_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            if (in_valid) begin
              op_q    <= op_e'(in_op);
              opnd_q  <= in_data;
              state_q <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_acc    = acc_q;
  assign out_carry  = carry_q;
  assign out_ovf    = ovf_q;
  assign sticky_ovf = sticky_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_accum20_unit.sv
// Self-checking bench for accum20_unit: directed literal cases plus randomized traffic against a transaction model.
module tb_accum20_unit;

  localparam int CNT_W = 4;
  localparam logic [1:0] C_ADD = 2'b00, C_SUB = 2'b01, C_LOAD = 2'b10, C_CLEAR = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [19:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [19:0]      out_acc;
  logic             out_carry;
  logic             out_ovf;
  logic             sticky_ovf;
  logic             clr_sticky = 1'b0;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int failures = 0;

  accum20_unit #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the opcode definitions
  task automatic calc(input logic [1:0] op, input logic [19:0] a, input logic [19:0] b,
                      output logic [19:0] r, output logic c, output logic v);
    logic [20:0] t;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      C_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[19:0];
        c = t[20];
        v = (a[19] == b[19]) && (r[19] != a[19]);
      end
      C_SUB: begin
        r = a - b;
        c = (a >= b);
        v = (a[19] != b[19]) && (r[19] != a[19]);
      end
      C_LOAD: r = b;
      default: r = '0;
    endcase
  endtask

  // Transaction-level model: one pending result, visible one cycle after acceptance
  logic             m_init = 1'b0;
  logic             m_pend = 1'b0;
  int               m_age = 0;
  logic [19:0]      m_acc = '0;
  logic             m_c = 1'b0;
  logic             m_v = 1'b0;
  logic             m_arith = 1'b0;
  logic             m_sticky = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_accept = 1'b0;

  always @(posedge clk) begin
    logic fire, rdy;
    logic [19:0] r;
    logic c, v;
    m_accept = 1'b0;
    if (rst) begin
      m_init = 1'b1; m_pend = 1'b0; m_age = 0; m_acc = '0;
      m_c = 1'b0; m_v = 1'b0; m_sticky = 1'b0; m_cnt = '0;
    end else begin
      fire = m_pend && (m_age >= 1) && out_ready;
      rdy  = !m_pend || fire;
      if (clr_sticky) m_sticky = 1'b0;
      if (m_pend && m_age == 0 && m_arith && m_v) m_sticky = 1'b1;
      if (fire) begin
        m_pend = 1'b0;
        if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      end else if (m_pend && m_age == 0) begin
        m_age = 1;
      end
      if (in_valid && rdy) begin
        calc(in_op, m_acc, in_data, r, c, v);
        m_acc = r; m_c = c; m_v = v;
        m_arith = (in_op == C_ADD) || (in_op == C_SUB);
        m_pend = 1'b1; m_age = 0; m_accept = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_pend && m_age >= 1});
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_pend || (m_age >= 1 && out_ready)});
      chk("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, m_sticky});
      chk("op_count", {28'd0, op_count}, {28'd0, m_cnt});
      if (m_pend && m_age >= 1) begin
        chk("out_acc", {12'd0, out_acc}, {12'd0, m_acc});
        chk("out_carry", {31'd0, out_carry}, {31'd0, m_c});
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, m_v});
      end
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [19:0] data);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; in_op = op; in_data = data;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      got = m_accept;
    end
    #1;
    in_valid = 1'b0; in_op = 2'($urandom); in_data = 20'($urandom);
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=none expected=accept op=%0d", op);
    end
  endtask

  task automatic wait_result(output logic [19:0] r, output logic c, output logic v);
    logic got;
    got = 1'b0; r = '0; c = 1'b0; v = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1; r = out_acc; c = out_carry; v = out_ovf;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL result_timeout actual=none expected=out_valid");
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    logic [19:0] r;
    logic c, v;
    int k, accepts, last_t;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acc", {12'd0, out_acc}, 32'd0);

    do_cmd(C_LOAD, 20'h7FFC2); wait_result(r, c, v);
    do_cmd(C_ADD, 20'h5BAC4);  wait_result(r, c, v);
    chk("add_acc", {12'd0, r}, 32'hDBA86);
    chk("add_carry", {31'd0, c}, 32'd0);
    chk("add_ovf", {31'd0, v}, 32'd1);
    @(negedge clk);
    chk("add_sticky", {31'd0, sticky_ovf}, 32'd1);
    chk("add_count", {28'd0, op_count}, 32'd2);

    do_cmd(C_LOAD, 20'h00005); wait_result(r, c, v);
    do_cmd(C_SUB, 20'h00007);  wait_result(r, c, v);
    chk("sub_neg_acc", {12'd0, r}, 32'hFFFFE);
    chk("sub_neg_carry", {31'd0, c}, 32'd0);
    chk("sub_neg_ovf", {31'd0, v}, 32'd0);

    do_cmd(C_LOAD, 20'h80000); wait_result(r, c, v);
    do_cmd(C_SUB, 20'h00001);  wait_result(r, c, v);
    chk("sub_ovf_acc", {12'd0, r}, 32'h7FFFF);
    chk("sub_ovf_carry", {31'd0, c}, 32'd1);
    chk("sub_ovf_ovf", {31'd0, v}, 32'd1);
    @(posedge clk); #2 clr_sticky = 1'b1;
    @(posedge clk); #2 clr_sticky = 1'b0;
    @(negedge clk);
    chk("clr_sticky", {31'd0, sticky_ovf}, 32'd0);

    out_ready = 1'b0;
    do_cmd(C_ADD, 20'h00123); wait_result(r, c, v);
    chk("bp_acc", {12'd0, r}, 32'h80122);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_acc_hold", {12'd0, out_acc}, 32'h80122);
    end
    @(posedge clk); #2;
    out_ready = 1'b1; in_valid = 1'b1; in_op = C_CLEAR; in_data = 20'hABCDE;
    @(negedge clk);
    chk("same_edge_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2 in_valid = 1'b0;
    wait_result(r, c, v);
    chk("clear_acc", {12'd0, r}, 32'd0);

    do_cmd(C_LOAD, 20'h00001); wait_result(r, c, v);
    do_cmd(C_ADD, 20'h00010);
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_acc", {12'd0, out_acc}, 32'd0);
    do_cmd(C_ADD, 20'h00003); wait_result(r, c, v);
    chk("after_rst_acc", {12'd0, r}, 32'd3);

    pulse_reset();
    in_valid = 1'b1; in_op = C_ADD; in_data = 20'h00001;
    k = 0; accepts = 0; last_t = 0;
    for (int cyc = 0; cyc < 80 && k < 10; cyc++) begin
      @(posedge clk); #1;
      if (m_accept) accepts++;
      if (accepts == 10) in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        k++;
        chk("b2b_acc", {12'd0, out_acc}, k);
        if (k > 1) chk("b2b_spacing", cyc - last_t, 32'd2);
        last_t = cyc;
      end
    end
    chk("b2b_results", k, 32'd10);
    @(negedge clk);
    chk("b2b_count", {28'd0, op_count}, 32'd10);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      rst        = ($urandom_range(0, 63) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_op      = 2'($urandom);
      in_data    = ($urandom_range(0, 3) == 0) ? 20'h7FFFF + 20'($urandom_range(0, 2)) : 20'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum20_unit.md
# accum20_unit

Sequential accumulator stage wrapped around the 20-bit carry-lookahead adder/subtractor. It accepts a stream of operand/opcode commands over a valid/ready handshake. Each command is applied to an internal 20-bit accumulator through the adder, and the result, carry and overflow are presented downstream over a second valid/ready handshake. It sits directly upstream of the adder as its only driver: it owns the A, B and SUB inputs and consumes Sum, Carry and OVF.

## Interface
- CNT_W, 16, width of completed-operation counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  block can accept command this cycle
- in_op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
- in_data  in  20  operand (two's complement)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_acc  out  20  accumulator value after the operation
- out_carry  out  1  adder carry-out (SUB: 1 = no borrow)
- out_ovf  out  1  signed overflow of this operation
- sticky_ovf  out  1  set by any overflowing ADD/SUB, held until cleared
- clr_sticky  in  1  clears sticky_ovf
- op_count  out  CNT_W  completed operations, saturating

## Operation
- FSM states: IDLE, EXEC, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready, register in_op and in_data into op_q and opnd_q, then go to EXEC.
- EXEC: in_ready=0. The adder sees A=acc_q, B=opnd_q, SUB=(op_q==SUB). Registers update on exit from EXEC, then go to HOLD:
  - ADD/SUB: acc_q<=Sum, carry_q<=Carry, ovf_q<=OVF.
  - LOAD: acc_q<=opnd_q, carry_q<=0, ovf_q<=0.
  - CLEAR: acc_q<=0, carry_q<=0, ovf_q<=0. opnd_q is ignored.
- HOLD: out_valid=1. Outputs stay stable until out_ready. in_ready=out_ready.
  - out_ready with no new command: go to IDLE.
  - out_ready with in_valid in the same cycle: the result is retired and the new command is captured in the same edge; go to EXEC.
- sticky_ovf is set on exit from EXEC when the op is ADD/SUB and OVF=1. It is cleared by clr_sticky. A set and a clear in the same cycle: set wins.
- op_count increments by 1 on every out_valid&&out_ready. It saturates at all-ones and does not wrap.
- Arithmetic is modulo 2^20. Carry and overflow are the adder's values unchanged, with no reinterpretation.

## Timing
- Reset (synchronous, priority over everything): state=IDLE, acc_q=0, opnd_q=0, op_q=ADD, carry_q=0, ovf_q=0, sticky_ovf=0, op_count=0, out_valid=0, in_ready=1 from the first cycle after reset.
- Latency: command accepted at edge N; out_valid is high from edge N+2.
- Throughput: one command per 2 cycles when out_ready is held high.
- Reset mid-operation, in EXEC or HOLD: the pending result is discarded and the accumulator returns to 0.
- out_valid never drops without out_ready. out_acc, out_carry and out_ovf do not change while out_valid&&!out_ready.
- in_data and in_op are sampled only at the accept edge. Changes after that edge do not affect the operation.

## Structure
- Shared package holds:
  - the opcode enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_LOAD=2'b10, OP_CLEAR=2'b11
  - the state encoding: IDLE, EXEC, HOLD
  - the data width constant DW=20
- One sub-module: the existing Bit20CLAAdder, instantiated once. Ports are A=acc_q, B=opnd_q, SUB, Sum, Carry, OVF.
- No other hierarchy. The FSM, registers and counter live in accum20_unit.

## Test plan
- Reset, then LOAD 0x7FFC2 then ADD 0x5BAC4, with out_ready=1 -> out_acc=0xDBA86, out_carry=0, out_ovf=1, sticky_ovf=1, op_count=2.
- LOAD 0x00005, SUB 0x00007 -> out_acc=0xFFFFE, out_carry=0, out_ovf=0.
- LOAD 0x80000, SUB 0x00001 -> out_acc=0x7FFFF, out_carry=1, out_ovf=1. Then pulse clr_sticky -> sticky_ovf=0 next cycle.
- Backpressure: out_ready=0 for 5 cycles after an ADD -> out_valid held high, out_acc stable, in_ready=0. On out_ready=1 with in_valid=1 (CLEAR) -> same-edge accept, next result out_acc=0.
- Reset asserted during EXEC of ADD 0x00010 with acc=0x00001 -> next cycle out_valid=0, state IDLE, acc 0. A following ADD 0x00003 yields 0x00003.
- Back-to-back commands with out_ready=1: 10 ADD 0x00001 -> results 1..10 at 2-cycle spacing, op_count=10.
